// File: rtl/tracking_pkg.sv
// Shared thresholds, coordinate width and pixel type for the green-target tracker.
// A pixel counts as target when it is strongly green with little red and blue.
package tracking_pkg;

  localparam int         COORD_W = 12;
  localparam logic [7:0] G_MIN   = 8'd128;
  localparam logic [7:0] RB_MAX  = 8'd64;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic logic is_target(input pixel_t p);
    return (p.g >= G_MIN) && (p.r < RB_MAX) && (p.b < RB_MAX);
  endfunction

endpackage

// File: rtl/tracking_fifo.sv
// Show-ahead input FIFO: rd_data is valid combinationally whenever empty is low.
// Writes while full and reads while empty are ignored; simultaneous push/pop keeps count steady.
module tracking_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock_50) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tracking.sv
// Per-frame bounding box of green target pixels; result pulses one cycle after the last pixel pops.
// Input FIFO drains one pixel per cycle; writes are dropped while in_full is high.
module tracking
  import tracking_pkg::*;
#(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               in_wr_en,
  input  logic [7:0]         oR,
  input  logic [7:0]         oG,
  input  logic [7:0]         oB,
  output logic               in_full,
  output logic               valid,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height
);

  pixel_t wr_pix;
  pixel_t pix;
  logic   fifo_empty;
  logic   pop;

  assign wr_pix = pixel_t'({oR, oG, oB});
  assign pop    = ~fifo_empty;

  tracking_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_50 (clock_50),
    .reset    (reset),
    .wr_en    (in_wr_en),
    .wr_data  (wr_pix),
    .rd_en    (pop),
    .rd_data  (pix),
    .full     (in_full),
    .empty    (fifo_empty)
  );

  coord_t x_cnt, y_cnt;
  coord_t min_x, max_x, min_y, max_y;
  logic   found;

  logic   tgt, last_col, last_row, frame_end;
  coord_t nx_min_x, nx_max_x, nx_min_y, nx_max_y;
  logic   nx_found;
  logic [COORD_W:0] sum_x, sum_y;

  // Box including the pixel popping this cycle, so the frame's final pixel counts.
  always_comb begin
    tgt       = pop && is_target(pix);
    last_col  = (x_cnt == coord_t'(WIDTH - 1));
    last_row  = (y_cnt == coord_t'(HEIGHT - 1));
    frame_end = pop && last_col && last_row;
    nx_found  = found || tgt;
    nx_min_x  = min_x;
    nx_max_x  = max_x;
    nx_min_y  = min_y;
    nx_max_y  = max_y;
    if (tgt) begin
      if (!found || x_cnt < min_x) nx_min_x = x_cnt;
      if (!found || x_cnt > max_x) nx_max_x = x_cnt;
      if (!found || y_cnt < min_y) nx_min_y = y_cnt;
      if (!found || y_cnt > max_y) nx_max_y = y_cnt;
    end
    sum_x = {1'b0, nx_min_x} + {1'b0, nx_max_x};
    sum_y = {1'b0, nx_min_y} + {1'b0, nx_max_y};
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      min_x    <= '0;
      max_x    <= '0;
      min_y    <= '0;
      max_y    <= '0;
      found    <= 1'b0;
      valid    <= 1'b0;
      center_x <= '0;
      center_y <= '0;
      width    <= '0;
      height   <= '0;
    end else begin
      valid <= 1'b0;
      if (pop) begin
        if (last_col) begin
          x_cnt <= '0;
          y_cnt <= last_row ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        valid <= 1'b1;
        if (nx_found) begin
          center_x <= sum_x[COORD_W:1];
          center_y <= sum_y[COORD_W:1];
          width    <= nx_max_x - nx_min_x + coord_t'(1);
          height   <= nx_max_y - nx_min_y + coord_t'(1);
        end else begin
          center_x <= '0;
          center_y <= '0;
          width    <= '0;
          height   <= '0;
        end
        found <= 1'b0;
        min_x <= '0;
        max_x <= '0;
        min_y <= '0;
        max_y <= '0;
      end else begin
        found <= nx_found;
        min_x <= nx_min_x;
        max_x <= nx_max_x;
        min_y <= nx_min_y;
        max_y <= nx_max_y;
      end
    end
  end

endmodule

// File: tb/tb_tracking.sv
// Scoreboard bench for tracking; a reduced 32x24 frame keeps each frame short.
module tb_tracking;

  localparam int W = 32;
  localparam int H = 24;

  logic        clock_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        in_wr_en = 1'b0;
  logic [7:0]  oR = '0, oG = '0, oB = '0;
  logic        in_full, valid;
  logic [11:0] center_x, center_y, width, height;

  tracking #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(16)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .in_wr_en (in_wr_en),
    .oR       (oR),
    .oG       (oG),
    .oB       (oB),
    .in_full  (in_full),
    .valid    (valid),
    .center_x (center_x),
    .center_y (center_y),
    .width    (width),
    .height   (height)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct packed {
    logic [11:0] cx;
    logic [11:0] cy;
    logic [11:0] w;
    logic [11:0] h;
  } res_t;

  res_t exp_q[$];
  res_t got_e;
  int   total = 0;
  int   bad   = 0;
  int   rx0, rx1, ry0, ry1;
  bit   decoys;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest queued expectation.
  always @(negedge clock_50) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got pulse cx=%0d cy=%0d w=%0d h=%0d expected none",
                 center_x, center_y, width, height);
      end else begin
        got_e = exp_q.pop_front();
        check("center_x", int'(center_x), int'(got_e.cx));
        check("center_y", int'(center_y), int'(got_e.cy));
        check("width",    int'(width),    int'(got_e.w));
        check("height",   int'(height),   int'(got_e.h));
      end
      if (prev_valid) begin
        total++;
        bad++;
        $display("FAIL valid_pulse_len: got 2+ cycles expected 1");
      end
    end
    prev_valid = valid;
  end

  function automatic logic [23:0] pix_at(input int x, input int y);
    if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1) return {8'd0, 8'd255, 8'd0};
    if (decoys) begin
      if (x == 3  && y == 2)  return {8'd63, 8'd128, 8'd63};
      if (x == 10 && y == 10) return {8'd64, 8'd255, 8'd0};
      if (x == 12 && y == 12) return {8'd0,  8'd127, 8'd0};
      if (x == 14 && y == 14) return {8'd0,  8'd255, 8'd64};
    end
    return 24'd0;
  endfunction

  // Streams one frame (or nrows of one) back-to-back; expected result is hand-computed by the caller.
  task automatic send_frame(input int x0, input int x1, input int y0, input int y1,
                            input bit dec, input bit expect_pulse,
                            input int ecx, input int ecy, input int ew, input int eh,
                            input int nrows);
    rx0 = x0; rx1 = x1; ry0 = y0; ry1 = y1; decoys = dec;
    if (expect_pulse) exp_q.push_back({12'(ecx), 12'(ecy), 12'(ew), 12'(eh)});
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < W; x++) begin
        in_wr_en = 1'b1;
        {oR, oG, oB} = pix_at(x, y);
        @(negedge clock_50);
      end
    end
    in_wr_en = 1'b0;
    {oR, oG, oB} = 24'd0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock_50);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock_50);
    check("rst_in_full",  int'(in_full),  0);
    check("rst_valid",    int'(valid),    0);
    check("rst_center_x", int'(center_x), 0);
    check("rst_center_y", int'(center_y), 0);
    check("rst_width",    int'(width),    0);
    check("rst_height",   int'(height),   0);
    reset = 1'b0;
    @(negedge clock_50);

    send_frame(16, 19, 5, 8, 1'b0, 1'b1, 17, 6, 4, 4, H);      // 4x4 block
    send_frame(-1, -1, -1, -1, 1'b0, 1'b1, 0, 0, 0, 0, H);     // all black
    send_frame(31, 31, 23, 23, 1'b0, 1'b1, 31, 23, 1, 1, H);   // last pixel of frame
    send_frame(-1, -1, -1, -1, 1'b1, 1'b1, 3, 2, 1, 1, H);     // threshold edges
    send_frame(2, 9, 3, 4, 1'b0, 1'b1, 5, 3, 8, 2, H);         // back-to-back A
    send_frame(20, 30, 10, 21, 1'b0, 1'b1, 25, 15, 11, 12, H); // back-to-back B
    drain("pending_after_frames");
    repeat (5) @(negedge clock_50);
    check("hold_center_x", int'(center_x), 25);
    check("hold_width",    int'(width),    11);

    // Stall the consumer and overfill the FIFO.
    force dut.pop = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check("in_full_before_write", int'(in_full), (i == 16) ? 1 : 0);
      in_wr_en = 1'b1;
      @(negedge clock_50);
    end
    in_wr_en = 1'b0;
    check("in_full_after_17", int'(in_full), 1);
    check("fifo_count", int'(dut.u_fifo.count), 16);
    release dut.pop;
    repeat (20) @(negedge clock_50);
    check("fifo_drained", int'(dut.fifo_empty), 1);
    check("pixels_popped", int'(dut.x_cnt), 16);

    // Partial frame with a target, aborted by reset.
    send_frame(5, 5, 5, 5, 1'b0, 1'b0, 0, 0, 0, 0, 10);
    reset = 1'b1;
    repeat (2) @(negedge clock_50);
    check("midrst_in_full", int'(in_full), 0);
    check("midrst_width",   int'(width),   0);
    reset = 1'b0;
    @(negedge clock_50);
    send_frame(0, 0, 0, 0, 1'b0, 1'b1, 0, 0, 1, 1, H);
    drain("pending_after_reset");
    repeat (5) @(negedge clock_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
